// File: rtl/turfio_cmd_router.sv
// turfio_cmd_router: steers bridge command packets to one of four TURFIO links and merges their responses.
// Ports:
//   wb_clk_i, wb_rst_i        clock, synchronous active-high reset
//   link_up_i                 per-link up flags
//   s_cmd_*                   command stream from the bridge (tdest selects the link)
//   m_link_cmd_*              per-link command streams, slice i = [i*DW +: DW]
//   s_link_resp_*             per-link single-beat response streams
//   m_resp_*                  merged response stream, tuser = source link
//   drop_count_o              four 8-bit saturating dropped-packet counters, link i = [i*8 +: 8]
// Build option: define TURFIO_CMD_ROUTER_DROP_CNT_EN to build the drop counters; otherwise drop_count_o is 0.
module turfio_cmd_router #(
   parameter int DW = 32
) (
   input  logic            wb_clk_i,
   input  logic            wb_rst_i,
   input  logic [3:0]      link_up_i,
   input  logic [DW-1:0]   s_cmd_tdata,
   input  logic            s_cmd_tvalid,
   output logic            s_cmd_tready,
   input  logic [1:0]      s_cmd_tdest,
   input  logic            s_cmd_tlast,
   output logic [4*DW-1:0] m_link_cmd_tdata,
   output logic [3:0]      m_link_cmd_tvalid,
   input  logic [3:0]      m_link_cmd_tready,
   output logic [3:0]      m_link_cmd_tlast,
   input  logic [4*DW-1:0] s_link_resp_tdata,
   input  logic [3:0]      s_link_resp_tvalid,
   output logic [3:0]      s_link_resp_tready,
   output logic [DW-1:0]   m_resp_tdata,
   output logic            m_resp_tvalid,
   input  logic            m_resp_tready,
   output logic [1:0]      m_resp_tuser,
   output logic [31:0]     drop_count_o
);
   typedef enum logic [1:0] {CMD_IDLE, CMD_PASS, CMD_DROP} state_t;
   state_t     state;
   logic [1:0] dest_reg;
   logic [1:0] last_grant;
   logic [1:0] grant;
   logic       grant_vld;
   logic       free;
   logic [3:0] cand;
   // link_up_i is only consulted here, so a link dropping mid-packet never aborts it
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state    <= CMD_IDLE;
         dest_reg <= 2'd0;
      end else begin
         case (state)
            CMD_IDLE: if (s_cmd_tvalid) begin
               dest_reg <= s_cmd_tdest;
               state    <= link_up_i[s_cmd_tdest] ? CMD_PASS : CMD_DROP;
            end
            CMD_PASS, CMD_DROP: if (s_cmd_tvalid && s_cmd_tready && s_cmd_tlast) state <= CMD_IDLE;
            default: state <= CMD_IDLE;
         endcase
      end
   end
   assign s_cmd_tready      = (state == CMD_PASS) ? m_link_cmd_tready[dest_reg] : (state == CMD_DROP);
   assign m_link_cmd_tvalid = (state == CMD_PASS && s_cmd_tvalid) ? 4'b0001 << dest_reg : 4'b0000;
   assign m_link_cmd_tdata  = {4{s_cmd_tdata}};
   assign m_link_cmd_tlast  = {4{s_cmd_tlast}};
   assign free = !m_resp_tvalid || m_resp_tready;
   assign cand = s_link_resp_tvalid & link_up_i;
   // Descending scan so the nearest link after last_grant wins; offset 4 wraps to last_grant itself
   always_comb begin
      grant_vld = 1'b0;
      grant     = last_grant;
      for (int k = 3; k >= 0; k--) begin
         if (cand[last_grant + 2'(k + 1)]) begin
            grant_vld = 1'b1;
            grant     = last_grant + 2'(k + 1);
         end
      end
   end
   // Down links are drained continuously so a dead TURFIO cannot block its response path
   assign s_link_resp_tready = ~link_up_i | ((free && grant_vld) ? 4'b0001 << grant : 4'b0000);
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         m_resp_tvalid <= 1'b0;
         m_resp_tdata  <= '0;
         m_resp_tuser  <= 2'd0;
         last_grant    <= 2'd3;
      end else if (free) begin
         m_resp_tvalid <= grant_vld;
         if (grant_vld) begin
            m_resp_tdata <= s_link_resp_tdata[grant*DW +: DW];
            m_resp_tuser <= grant;
            last_grant   <= grant;
         end
      end
   end
`ifdef TURFIO_CMD_ROUTER_DROP_CNT_EN
   logic [7:0] drop_cnt [4];
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         for (int i = 0; i < 4; i++) drop_cnt[i] <= 8'd0;
      end else if (state == CMD_DROP && s_cmd_tvalid && s_cmd_tlast && drop_cnt[dest_reg] != 8'hFF) begin
         drop_cnt[dest_reg] <= drop_cnt[dest_reg] + 8'd1;
      end
   end
   assign drop_count_o = {drop_cnt[3], drop_cnt[2], drop_cnt[1], drop_cnt[0]};
`else
   assign drop_count_o = 32'd0;
`endif
endmodule
